// File: rtl/pong_pkg.sv
// Shared Pong definitions: board defaults, direction encodings and the ball FSM states.
package pong_pkg;

  localparam int unsigned GAME_WIDTH_DEF  = 40;
  localparam int unsigned GAME_HEIGHT_DEF = 30;

  localparam logic RIGHT = 1'b0;
  localparam logic LEFT  = 1'b1;
  localparam logic UP    = 1'b1;
  localparam logic DOWN  = 1'b0;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/ball_motion_if.sv
// Direction inputs and position/status outputs of the ball motion block.
interface ball_motion_if #(
  parameter int unsigned X_W = 6,
  parameter int unsigned Y_W = 5
);
  logic           i_Game_Active;
  logic           i_HDir;
  logic           i_VDir;
  logic [X_W-1:0] o_Ball_X;
  logic [Y_W-1:0] o_Ball_Y;
  logic           o_Step;
  logic           o_At_HEdge;
  logic           o_At_VEdge;

  modport master (
    output i_Game_Active, i_HDir, i_VDir,
    input  o_Ball_X, o_Ball_Y, o_Step, o_At_HEdge, o_At_VEdge
  );

  modport slave (
    input  i_Game_Active, i_HDir, i_VDir,
    output o_Ball_X, o_Ball_Y, o_Step, o_At_HEdge, o_At_VEdge
  );
endinterface

// File: rtl/step_timer.sv
// Free-running interval counter; tick_c marks the edge that completes each BALL_SPEED-clock interval.
module step_timer #(
  parameter int unsigned BALL_SPEED = 1250000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick_c
);
  localparam int unsigned CNT_W = (BALL_SPEED > 1) ? $clog2(BALL_SPEED) : 1;

  logic [CNT_W-1:0] cnt;

  // Full-width compare so the terminal count is never truncated.
  assign tick_c = enable && (32'(cnt) == BALL_SPEED - 1);

  always_ff @(posedge clk) begin
    if (reset || !enable || tick_c) cnt <= '0;
    else                            cnt <= cnt + CNT_W'(1);
  end
endmodule

// File: rtl/ball_motion.sv
// Ball position on the Pong grid: steps one tile per axis every BALL_SPEED clocks, saturating at walls.
module ball_motion
  import pong_pkg::*;
#(
  parameter int unsigned GAME_WIDTH  = GAME_WIDTH_DEF,
  parameter int unsigned GAME_HEIGHT = GAME_HEIGHT_DEF,
  parameter int unsigned BALL_SPEED  = 1250000
) (
  input logic          i_Clk,
  input logic          i_Reset,
  ball_motion_if.slave bus
);
  localparam int unsigned X_W = $clog2(GAME_WIDTH);
  localparam int unsigned Y_W = $clog2(GAME_HEIGHT);
  localparam logic [X_W-1:0] X_MAX = X_W'(GAME_WIDTH - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(GAME_HEIGHT - 1);
  localparam logic [X_W-1:0] X_CTR = X_W'(GAME_WIDTH / 2);
  localparam logic [Y_W-1:0] Y_CTR = Y_W'(GAME_HEIGHT / 2);

  state_t         state, state_nxt;
  logic [X_W-1:0] x, x_nxt;
  logic [Y_W-1:0] y, y_nxt;
  logic           step, step_nxt;
  logic           hedge, vedge;
  logic           run_c;
  logic           tick_c;

  assign run_c = (state == RUN) && bus.i_Game_Active;

  step_timer #(.BALL_SPEED(BALL_SPEED)) u_timer (
    .clk   (i_Clk),
    .reset (i_Reset),
    .enable(run_c),
    .tick_c(tick_c)
  );

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state <= IDLE;
      x     <= X_CTR;
      y     <= Y_CTR;
      step  <= 1'b0;
      hedge <= (X_CTR == '0) || (X_CTR == X_MAX);
      vedge <= (Y_CTR == '0) || (Y_CTR == Y_MAX);
    end else begin
      state <= state_nxt;
      x     <= x_nxt;
      y     <= y_nxt;
      step  <= step_nxt;
      hedge <= (x_nxt == '0) || (x_nxt == X_MAX);
      vedge <= (y_nxt == '0) || (y_nxt == Y_MAX);
    end
  end

  // Dropping Game_Active parks the ball and takes priority over a coincident step.
  always_comb begin
    state_nxt = state;
    x_nxt     = x;
    y_nxt     = y;
    step_nxt  = 1'b0;
    case (state)
      IDLE: begin
        x_nxt = X_CTR;
        y_nxt = Y_CTR;
        if (bus.i_Game_Active) state_nxt = RUN;
      end
      RUN: begin
        if (!bus.i_Game_Active) begin
          state_nxt = IDLE;
          x_nxt     = X_CTR;
          y_nxt     = Y_CTR;
        end else if (tick_c) begin
          step_nxt = 1'b1;
          if (bus.i_HDir == RIGHT && x < X_MAX)      x_nxt = x + X_W'(1);
          else if (bus.i_HDir == LEFT && x != '0)    x_nxt = x - X_W'(1);
          if (bus.i_VDir == UP && y != '0)           y_nxt = y - Y_W'(1);
          else if (bus.i_VDir == DOWN && y < Y_MAX)  y_nxt = y + Y_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.o_Ball_X   = x;
  assign bus.o_Ball_Y   = y;
  assign bus.o_Step     = step;
  assign bus.o_At_HEdge = hedge;
  assign bus.o_At_VEdge = vedge;
endmodule

// File: tb/tb_ball_motion.sv
// Scoreboard bench: BALL_SPEED=4 and BALL_SPEED=1 instances, expected steps queued by stimulus, popped on o_Step.
module tb_ball_motion;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    int cyc;
    int x;
    int y;
    int he;
    int ve;
  } exp_t;

  exp_t q4[$];
  exp_t q1[$];
  exp_t e4, e1;

  ball_motion_if #(.X_W(6), .Y_W(5)) b4();
  ball_motion_if #(.X_W(6), .Y_W(5)) b1();

  ball_motion #(.GAME_WIDTH(40), .GAME_HEIGHT(30), .BALL_SPEED(4)) dut4 (
    .i_Clk(clk), .i_Reset(rst), .bus(b4)
  );
  ball_motion #(.GAME_WIDTH(40), .GAME_HEIGHT(30), .BALL_SPEED(1)) dut1 (
    .i_Clk(clk), .i_Reset(rst), .bus(b1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d required finish", cyc);
    $fatal(1);
  end

  function automatic exp_t mk(int c, int x, int y);
    exp_t e;
    e.cyc = c; e.x = x; e.y = y;
    e.he = (x == 0 || x == 39) ? 1 : 0;
    e.ve = (y == 0 || y == 29) ? 1 : 0;
    return e;
  endfunction

  // Monitors: every o_Step pulse must match the next queued expectation, including its cycle.
  always @(negedge clk) begin
    if (b4.o_Step === 1'b1) begin
      checks++;
      if (q4.size() == 0) begin
        errors++;
        $display("FAIL step4_unexpected cyc=%0d x=%0d y=%0d required no step", cyc, b4.o_Ball_X, b4.o_Ball_Y);
      end else begin
        e4 = q4.pop_front();
        if (cyc != e4.cyc || int'(b4.o_Ball_X) != e4.x || int'(b4.o_Ball_Y) != e4.y ||
            int'(b4.o_At_HEdge) != e4.he || int'(b4.o_At_VEdge) != e4.ve) begin
          errors++;
          $display("FAIL step4 got cyc=%0d x=%0d y=%0d he=%0d ve=%0d required cyc=%0d x=%0d y=%0d he=%0d ve=%0d",
                   cyc, b4.o_Ball_X, b4.o_Ball_Y, b4.o_At_HEdge, b4.o_At_VEdge,
                   e4.cyc, e4.x, e4.y, e4.he, e4.ve);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (b1.o_Step === 1'b1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL step1_unexpected cyc=%0d x=%0d y=%0d required no step", cyc, b1.o_Ball_X, b1.o_Ball_Y);
      end else begin
        e1 = q1.pop_front();
        if (cyc != e1.cyc || int'(b1.o_Ball_X) != e1.x || int'(b1.o_Ball_Y) != e1.y ||
            int'(b1.o_At_HEdge) != e1.he || int'(b1.o_At_VEdge) != e1.ve) begin
          errors++;
          $display("FAIL step1 got cyc=%0d x=%0d y=%0d he=%0d ve=%0d required cyc=%0d x=%0d y=%0d he=%0d ve=%0d",
                   cyc, b1.o_Ball_X, b1.o_Ball_Y, b1.o_At_HEdge, b1.o_At_VEdge,
                   e1.cyc, e1.x, e1.y, e1.he, e1.ve);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) adv();
  endtask

  initial begin
    int k, s, x, y;
    rst = 1'b1;
    b4.i_Game_Active = 1'b0; b4.i_HDir = 1'b0; b4.i_VDir = 1'b0;
    b1.i_Game_Active = 1'b0; b1.i_HDir = 1'b0; b1.i_VDir = 1'b0;
    repeat (3) adv();
    check("rst_x", int'(b4.o_Ball_X), 20);
    check("rst_y", int'(b4.o_Ball_Y), 15);
    check("rst_step", int'(b4.o_Step), 0);
    check("rst_hedge", int'(b4.o_At_HEdge), 0);
    check("rst_vedge", int'(b4.o_At_VEdge), 0);
    check("rst_x1", int'(b1.o_Ball_X), 20);
    rst = 1'b0;
    repeat (2) adv();
    check("idle_x", int'(b4.o_Ball_X), 20);

    // Right/up from centre: first step 4 clocks after RUN entry.
    b4.i_HDir = 1'b0; b4.i_VDir = 1'b1; b4.i_Game_Active = 1'b1;
    k = cyc;
    q4.push_back(mk(k + 5, 21, 14));
    q4.push_back(mk(k + 9, 22, 13));
    wait_until(k + 2);
    check("pre_step_x", int'(b4.o_Ball_X), 20);
    wait_until(k + 9);

    // Left/up into the corner and hold there.
    b4.i_HDir = 1'b1; b4.i_VDir = 1'b1;
    x = 22; y = 13; s = k + 9;
    for (int n = 0; n < 24; n++) begin
      x = (x > 0) ? x - 1 : 0;
      y = (y > 0) ? y - 1 : 0;
      s += 4;
      q4.push_back(mk(s, x, y));
    end
    wait_until(s);

    // Direction wiggles between steps; only the step-edge sample counts.
    b4.i_HDir = 1'b1; b4.i_VDir = 1'b0; adv();
    b4.i_HDir = 1'b0; adv();
    b4.i_HDir = 1'b1; adv();
    b4.i_HDir = 1'b0;
    q4.push_back(mk(s + 4, 1, 1));
    wait_until(s + 4);

    // Drop Game_Active mid-interval, then re-enable.
    wait_until(s + 6);
    b4.i_Game_Active = 1'b0;
    adv();
    check("drop_x", int'(b4.o_Ball_X), 20);
    check("drop_y", int'(b4.o_Ball_Y), 15);
    check("drop_step", int'(b4.o_Step), 0);
    b4.i_Game_Active = 1'b1;
    k = cyc;
    for (int n = 0; n < 10; n++) q4.push_back(mk(k + 5 + 4 * n, 21 + n, 16 + n));
    wait_until(k + 41);
    check("pre_rst_x", int'(b4.o_Ball_X), 30);

    // Reset on the step edge.
    wait_until(k + 44);
    rst = 1'b1;
    adv();
    check("mid_rst_x", int'(b4.o_Ball_X), 20);
    check("mid_rst_y", int'(b4.o_Ball_Y), 15);
    check("mid_rst_step", int'(b4.o_Step), 0);
    rst = 1'b0;
    b4.i_Game_Active = 1'b0;
    adv();
    check("post_rst_step", int'(b4.o_Step), 0);

    // BALL_SPEED=1: a step every RUN cycle, saturating at 39/29.
    b1.i_HDir = 1'b0; b1.i_VDir = 1'b0; b1.i_Game_Active = 1'b1;
    k = cyc;
    for (int n = 0; n < 22; n++)
      q1.push_back(mk(k + 2 + n, (21 + n > 39) ? 39 : 21 + n, (16 + n > 29) ? 29 : 16 + n));
    wait_until(k + 23);
    b1.i_Game_Active = 1'b0;
    adv();
    check("b1_stop_step", int'(b1.o_Step), 0);
    check("b1_stop_x", int'(b1.o_Ball_X), 20);

    repeat (4) adv();
    check("q4_left", q4.size(), 0);
    check("q1_left", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ball_motion.md
Name: ball_motion

Overview:
- Downstream consumer of the direction-control stage's o_HDir/o_VDir.
- Holds the ball position on the Pong game grid in tile units. Advances it one tile per axis every BALL_SPEED clocks while a game is active.
- Saturates at the board walls. Its position outputs feed the ball renderer and the paddle/score logic.

Parameters:
- GAME_WIDTH, 40: board width in tiles; X range 0..GAME_WIDTH-1.
- GAME_HEIGHT, 30: board height in tiles; Y range 0..GAME_HEIGHT-1.
- BALL_SPEED, 1250000: clocks per movement step; must be >= 1. The default gives 20 steps/s at 25 MHz.

Ports:
- i_Clk  in  1  system clock.
- i_Reset  in  1  synchronous, active-high reset.
- i_Game_Active  in  1  high = ball moves, low = ball parked at centre.
- i_HDir  in  1  0 = RIGHT (X+1), 1 = LEFT (X-1).
- i_VDir  in  1  1 = UP (Y-1), 0 = DOWN (Y+1); screen Y grows downward.
- o_Ball_X  out  clog2(GAME_WIDTH) (6 at default)  ball column.
- o_Ball_Y  out  clog2(GAME_HEIGHT) (5 at default)  ball row.
- o_Step  out  1  one-cycle pulse, high in the cycle after a position update.
- o_At_HEdge  out  1  level: X == 0 or X == GAME_WIDTH-1.
- o_At_VEdge  out  1  level: Y == 0 or Y == GAME_HEIGHT-1.

Behaviour:
- Clock and reset: one clock, i_Clk. Reset is synchronous and active-high on i_Reset, and dominates all other inputs.
- Reset values: state IDLE, X = GAME_WIDTH/2 (20), Y = GAME_HEIGHT/2 (15), step counter 0, o_Step 0.
- o_At_HEdge and o_At_VEdge are decoded from the registered X/Y, so they are 0 after reset at default sizes.
- FSM states: IDLE, RUN.
- IDLE:
  - X and Y are forced to centre; counter held at 0; o_Step 0.
  - Moves to RUN on the first clock edge where i_Game_Active = 1.
- RUN:
  - Counter increments each clock.
  - When counter == BALL_SPEED-1, the counter wraps to 0 and a step is performed in the same edge.
- Step rules:
  - i_HDir and i_VDir are sampled only on the step edge. Direction changes between steps have no effect until the next step.
  - X: RIGHT with X < GAME_WIDTH-1 gives X+1; LEFT with X > 0 gives X-1; otherwise X holds (saturates, no wrap-around).
  - Y: UP with Y > 0 gives Y-1; DOWN with Y < GAME_HEIGHT-1 gives Y+1; otherwise Y holds.
  - X and Y are updated independently in the same step; a corner saturates both.
- o_Step:
  - Registered; high for exactly one cycle after every step edge, including steps where both axes saturated.
  - Never high two cycles in a row unless BALL_SPEED = 1.
- Step timing:
  - First step occurs BALL_SPEED clocks after entering RUN.
  - With BALL_SPEED = 1 a step occurs every RUN cycle.
- i_Game_Active falls during RUN (mid-interval included):
  - Next edge: state IDLE, X/Y back to centre, counter 0.
  - Any pending partial interval is discarded.
- i_Game_Active low on a would-be step edge: the IDLE transition wins; no step, no o_Step.
- Reset mid-RUN: next edge equals the post-reset state regardless of i_Game_Active.
- Counter width: clog2(BALL_SPEED) bits, minimum 1. Compare against BALL_SPEED-1 at full width to avoid truncation.

Decomposition:
- Shared package pong_pkg:
  - Direction constants RIGHT=0, LEFT=1, UP=1, DOWN=0.
  - GAME_WIDTH/GAME_HEIGHT defaults.
  - FSM state encoding for IDLE/RUN.
- One sub-module, step_timer:
  - Parameter BALL_SPEED; inputs clock, reset, enable; output one-cycle tick.
  - Counter clears when enable is low.
  - ball_motion instantiates it with enable = (state == RUN && i_Game_Active).

Test Plan (BALL_SPEED=4, default board unless stated):
- Reset, then i_Game_Active=1, i_HDir=0, i_VDir=1 -> X=20/Y=15 for 4 clocks after RUN entry. Then X=21, Y=14 with o_Step high one cycle; next step 8 clocks after entry gives X=22, Y=13.
- Run with HDir=LEFT, VDir=UP until the corner -> X and Y reach 0 and hold. o_At_HEdge=o_At_VEdge=1, o_Step still pulses every 4 clocks, no wrap to 39/29.
- Toggle i_HDir for 3 cycles between steps, returning it to RIGHT before the step edge -> X increments (only the step-edge sample counts).
- Drop i_Game_Active 2 clocks after a step -> next edge X=20, Y=15, state IDLE. On re-enable, the first step comes a full 4 clocks later.
- Assert i_Reset on a step edge while at X=30 -> X=20, Y=15, o_Step=0, counter 0.
- BALL_SPEED=1, RIGHT/DOWN from centre -> X and Y advance every cycle. Y saturates at 29 after 14 cycles and X at 39 after 19 cycles; o_Step continuously high.
